// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/execute controller that issues operations to a registered ALU
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        halted
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, CMP, BWB, HALT} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic z_q, z_d;
  logic [31:0] pc4, sext;
  logic [2:0] r_op;
  logic is_r, is_beq, is_j, is_halt, is_exec;
  assign pc4 = pc_q + 32'd4;
  assign sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign is_halt = ir_q == 32'hFFFF_FFFF;
  assign is_r = ir_q[31:26] == 6'b000000;
  assign is_beq = ir_q[31:26] == 6'b000100;
  assign is_j = ir_q[31:26] == 6'b000010;
  // r_op of 0 marks an unsupported funct, which is treated as a NOP
  assign r_op = ir_q[5:0] == 6'h20 ? 3'd1 :
                ir_q[5:0] == 6'h22 ? 3'd2 :
                ir_q[5:0] == 6'h24 ? 3'd3 :
                ir_q[5:0] == 6'h25 ? 3'd4 :
                ir_q[5:0] == 6'h26 ? 3'd5 :
                ir_q[5:0] == 6'h2a ? 3'd6 : 3'd0;
  assign is_exec = (is_r && r_op != 3'd0) || is_beq || is_j;
  assign imem_addr = pc_q;
  assign rf_raddr1 = ir_q[25:21];
  assign rf_raddr2 = ir_q[20:16];
  assign halted = state_q == HALT;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    a_d = a_q;
    b_d = b_q;
    z_d = z_q;
    alu_op = 3'd1;
    alu_in1 = '0;
    alu_in2 = '0;
    rf_we = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (state_q)
      FETCH: begin
        ir_d = imem_data;
        state_d = DECODE;
      end
      DECODE: begin
        a_d = rf_rdata1;
        b_d = rf_rdata2;
        state_d = is_halt ? HALT : is_exec ? EXEC : FETCH;
        pc_d = (is_halt || is_exec) ? pc_q : pc4;
      end
      EXEC: begin
        alu_op = is_j ? 3'd7 : is_beq ? 3'd2 : r_op;
        alu_in1 = is_j ? {6'b0, ir_q[25:0]} : a_q;
        alu_in2 = is_j ? pc4 : b_q;
        state_d = is_beq ? CMP : WB;
      end
      WB: begin
        rf_we = is_r && ir_q[15:11] != 5'd0;
        rf_waddr = is_r ? ir_q[15:11] : 5'd0;
        rf_wdata = is_r ? alu_result : 32'd0;
        pc_d = is_j ? alu_result : pc4;
        state_d = FETCH;
      end
      // ALU op 000 folds the +4 and <<2 of the branch target into in2 = PC+5
      CMP: begin
        z_d = alu_zero;
        alu_op = 3'd0;
        alu_in1 = sext;
        alu_in2 = pc_q + 32'd5;
        state_d = BWB;
      end
      BWB: begin
        pc_d = z_q ? alu_result : pc4;
        state_d = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q <= '0;
      ir_q <= '0;
      a_q <= '0;
      b_q <= '0;
      z_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q <= a_d;
      b_q <= b_d;
      z_q <= z_d;
    end
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control unit that issues operations to the registered `ALU` and consumes its `output_result`/`zero`. It is the initiator end of the ALU interface. It holds the PC and instruction register, fetches and decodes one instruction at a time, and reads operands from the register file. It drives `alu_op`/operands, waits out the ALU's one-cycle latency, and writes results back or updates the PC. It sits between instruction memory, the register file and the ALU in the Lab2 datapath; top level drives the ALU's `reset` from `~reset`.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `imem_addr` out 32: instruction address (= PC).
- `imem_data` in 32: instruction word, combinational read of `imem_addr`.
- `rf_raddr1`, `rf_raddr2` out 5: register file read addresses (rs, rt).
- `rf_rdata1`, `rf_rdata2` in 32: combinational read data.
- `rf_we` out 1, `rf_waddr` out 5, `rf_wdata` out 32: register write port, sampled by the register file at the rising edge.
- `alu_op` out 3, `alu_in1` out 32, `alu_in2` out 32: ALU command and operands.
- `alu_result` in 32, `alu_zero` in 1: registered ALU output, valid one cycle after issue.
- `halted` out 1: high once a HALT word is executed.

## Operation
- Instruction fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0] (sign-extended), target [25:0], funct [5:0].
- R-type, opcode 000000, maps funct to `alu_op`: 100000 ADD→001, 100010 SUB→010, 100100 AND→011, 100101 OR→100, 100110 XOR→101, 101010 SLT→110. Any other funct is a NOP.
- BEQ, opcode 000100:
  - Compare: SUB (010) of rs and rt; latch `alu_zero`.
  - Target: op 000 with `alu_in1`=sext(imm) and `alu_in2`=PC+5, so result = PC+4+(sext(imm)<<2).
- J, opcode 000010: op 111 with `alu_in1`={6'b0,target} and `alu_in2`=PC+4, so result = {PC+4[31:28... via [31:26]], target<<2}.
- HALT: word 0xFFFFFFFF. Any other opcode is a NOP (PC+4).
- States:
  - FETCH: IR←`imem_data`; go to DECODE.
  - DECODE: `rf_raddr1`=rs, `rf_raddr2`=rt. Latch A←`rf_rdata1`, B←`rf_rdata2`.
    - R-type or J → EXEC.
    - BEQ → EXEC.
    - NOP → FETCH with PC+4.
    - HALT → HALT.
  - EXEC: drive op/operands; the ALU samples them at the end of this cycle.
    - R-type/J → WB.
    - BEQ → CMP.
  - WB: `alu_result` valid.
    - R-type: `rf_we`=1, `rf_waddr`=rd, `rf_wdata`=`alu_result`, PC+4. Suppress `rf_we` when rd=0.
    - J: PC←`alu_result`.
    - Both → FETCH.
  - CMP: Z←`alu_zero`; issue op 000 target computation; → BWB.
  - BWB: PC←Z ? `alu_result` : PC+4; → FETCH.
  - HALT: terminal; `halted`=1; only reset leaves it.
- `alu_op`/`alu_in1`/`alu_in2` come only from internal registers (IR, A, B, PC, state). There is no combinational path from `imem_data`/`rf_rdata*`.
- Outside EXEC/CMP, `alu_op`=001 and operands=0.
- All PC arithmetic is modulo 2^32.

## Timing
- Reset values:
  - PC=0, state=FETCH, IR=0, A=B=0, Z=0.
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0.
  - `alu_op`=001, `alu_in1`=`alu_in2`=0, `halted`=0.
- Cycles per instruction:
  - R-type: 4.
  - J: 4.
  - BEQ: 5.
  - NOP/unknown: 2.
  - HALT: 2 to assert `halted`.
- Counting from the FETCH cycle (cycle 1):
  - R-type: `rf_we` pulses for exactly 1 cycle in cycle 4.
  - R-type, J: new PC visible on `imem_addr` in cycle 5.
  - BEQ: new PC visible in cycle 6.
- `alu_zero` is used only in CMP. A zero output in any other state is ignored.
- Reset asserted in any state, including WB with `rf_we`=1:
  - All outputs take reset values immediately.
  - No write completes after the asynchronous assertion.
  - Execution restarts at PC=0 on the first rising edge after deassertion.
- PC=0xFFFFFFFC with NOP wraps to 0.

## Test plan
- Reset, then release: `imem_addr`=0, `rf_we`=0, `alu_op`=001, `halted`=0 before the first edge; FETCH at PC 0.
- r1=5, r2=3; `imem_data`=0x00221820 (ADD r3,r1,r2) at PC 0:
  - EXEC cycle: `alu_op`=001, `alu_in1`=5, `alu_in2`=3.
  - Cycle 4: `rf_we`=1, `rf_waddr`=3, `rf_wdata`=8.
  - Next fetch at 0x4.
- BEQ 0x10210002 at PC 0x10 with r1=r1: `imem_addr`=0x1C in cycle 6. Same encoding with rt=r2 (0x10220002), r2≠r1: `imem_addr`=0x14, and no `rf_we` either way.
- J 0x08000010 at PC 0x20:
  - EXEC: `alu_op`=111, `alu_in1`=0x10, `alu_in2`=0x24.
  - Next `imem_addr`=0x40.
- SLT with rd=0 (r1=2, r2=7): ALU sees 110, `rf_we` stays 0. Unknown opcode 0x3C000000: PC+4 after 2 cycles.
- HALT 0xFFFFFFFF: `halted`=1 and PC frozen for 20 cycles. Assert reset mid-WB of an ADD: `rf_we` drops immediately, PC=0 after release.
